// File: rtl/serpent_stream_ctrl.sv
// Valid/ready shell around a fixed-latency, non-stallable Serpent core.
// Tags ride a shift register beside the core; results land in a credit-guarded FIFO.
module serpent_stream_ctrl #(
   parameter int DATA_W     = 128,
   parameter int LATENCY    = 33,
   parameter int TAG_W      = 4,
   parameter int FIFO_DEPTH = 64
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [DATA_W-1:0]                 s_data,
   input  logic [TAG_W-1:0]                  s_tag,
   output logic [DATA_W-1:0]                 core_din,
   input  logic [DATA_W-1:0]                 core_dout,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [DATA_W-1:0]                 m_data,
   output logic [TAG_W-1:0]                  m_tag,
   output logic [$clog2(LATENCY+1)-1:0]      inflight,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt
);

   localparam int INF_W = $clog2(LATENCY + 1);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int SUM_W = ((INF_W > CNT_W) ? INF_W : CNT_W) + 1;
   localparam int ENT_W = DATA_W + TAG_W;

   logic [LATENCY-1:0] r_vld_sr;
   logic [TAG_W-1:0]   r_tag_sr [LATENCY];
   logic [INF_W-1:0]   r_inflight;
   logic [CNT_W-1:0]   r_fifo_cnt;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];

   logic [SUM_W-1:0]   w_credit_sum;
   logic               w_accept;
   logic               w_exit;
   logic               w_pop;
   logic [ENT_W-1:0]   w_head;

   // Every accepted block holds a FIFO slot from acceptance onwards, so the
   // core can never deliver into a full FIFO no matter how long m_ready stalls.
   assign w_credit_sum = SUM_W'(r_inflight) + SUM_W'(r_fifo_cnt);
   assign s_ready      = rst_n & (w_credit_sum < SUM_W'(FIFO_DEPTH));
   assign w_accept     = s_valid & s_ready;
   assign w_exit       = r_vld_sr[LATENCY-1];
   assign m_valid      = rst_n & (r_fifo_cnt != '0);
   assign w_pop        = m_valid & m_ready;

   assign core_din = s_data;
   assign w_head   = r_mem[r_rd_ptr];
   assign m_data   = w_head[DATA_W-1:0];
   assign m_tag    = w_head[DATA_W +: TAG_W];
   assign inflight = r_inflight;
   assign fifo_cnt = r_fifo_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_sr <= '0;
         for (int i = 0; i < LATENCY; i++) r_tag_sr[i] <= '0;
      end else begin
         r_vld_sr[0] <= w_accept;
         r_tag_sr[0] <= s_tag;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld_sr[i] <= r_vld_sr[i-1];
            r_tag_sr[i] <= r_tag_sr[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_inflight <= '0;
         r_fifo_cnt <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
      end else begin
         case ({w_accept, w_exit})
            2'b10:   r_inflight <= r_inflight + INF_W'(1);
            2'b01:   r_inflight <= r_inflight - INF_W'(1);
            default: r_inflight <= r_inflight;
         endcase
         case ({w_exit, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
         if (w_exit) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // Data RAM is intentionally not reset; pointers and counts define validity.
   always_ff @(posedge clk) begin
      if (w_exit) r_mem[r_wr_ptr] <= {r_tag_sr[LATENCY-1], core_dout};
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         a_push_full:  assert (!(w_exit && (r_fifo_cnt == CNT_W'(FIFO_DEPTH))));
         a_pop_empty:  assert (!(w_pop && (r_fifo_cnt == '0)));
         a_inflight:   assert (r_inflight <= INF_W'(LATENCY));
      end
   end

endmodule
